// File: rtl/mem_resp_pkg.sv
// Shared types for the block responder: FSM states, op encoding, block geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

    localparam int WORD_W  = 32;
    localparam int WORDS   = 4;
    localparam int BLOCK_W = WORD_W * WORDS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        BURST = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 storage: synchronous write, combinational read, zeroed on reset.
// Latency: write lands on the next clk edge; read data is same-cycle.
// Backpressure: none, one access per port per cycle.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_block_responder.sv
// Main-memory responder: 4-word block reads, single-word writes, fixed access delay.
// Latency: read ready at E0+LATENCY+WORDS, write ready at E0+LATENCY+1.
// Backpressure: level requests held until ready; DONE lingers until both requests drop.
module mem_block_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_index,
    input  logic               write_index,
    input  logic [31:0]        addr,
    input  logic [31:0]        write_data,
    output logic               busy,
    output logic               ready,
    output logic [BLOCK_W-1:0] block_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    op_t               op;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     burst_idx;
    logic [AW-1:0]     cap_idx;
    logic [WORD_W-1:0] cap_data;
    logic [WORD_W-1:0] rd_data;
    logic [AW-1:0]     rd_addr;
    logic              mem_we;

    // Only the word index inside the array is meaningful; the rest wraps away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (write_index || read_index) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = (op == OP_WR) ? WRITE : BURST;
                end
            end
            BURST: begin
                busy = 1'b1;
                if (burst_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy  = 1'b1;
                ready = 1'b1;
                if (!read_index && !write_index) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op        <= OP_RD;
            cnt       <= '0;
            burst_idx <= '0;
            cap_idx   <= '0;
            cap_data  <= '0;
            block_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    // Write wins a collision; the read stays pending at the requester.
                    if (write_index) begin
                        op       <= OP_WR;
                        cap_idx  <= addr[AW+1:2];
                        cap_data <= write_data;
                        cnt      <= CNT_INIT;
                    end else if (read_index) begin
                        op      <= OP_RD;
                        cap_idx <= addr[AW+1:2];
                        cnt     <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        burst_idx <= '0;
                    end
                end
                BURST: begin
                    block_out[int'(burst_idx)*WORD_W +: WORD_W] <= rd_data;
                    burst_idx <= burst_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_addr = {cap_idx[AW-1:BW], burst_idx};
    assign mem_we  = (state == WRITE);

    mem_resp_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (cap_idx),
        .wdata (cap_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: ready timing, refill contents, resets.
module tb_mem_block_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_index;
    logic         write_index;
    logic [31:0]  addr;
    logic [31:0]  write_data;
    logic         busy;
    logic         ready;
    logic [127:0] block_out;

    typedef struct {
        bit           is_rd;
        logic [127:0] blk;
        int           cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ready_cnt = 0;
    logic        ready_q = 1'b0;

    mem_block_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_index  (read_index),
        .write_index (write_index),
        .addr        (addr),
        .write_data  (write_data),
        .busy        (busy),
        .ready       (ready),
        .block_out   (block_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [31:0] a);
        logic [127:0] b;
        logic [9:0]   base;
        base = {a[11:4], 2'b00};
        for (int k = 0; k < 4; k++) begin
            b[32*k +: 32] = model_mem[base + 10'(k)];
        end
        return b;
    endfunction

    // Completion monitor: every rising ready retires the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ready) ready_cnt++;
            if (ready && !ready_q) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("ready_edge", 128'(cyc), 128'(e.cyc));
                    if (e.is_rd) check_val("block", block_out, e.blk);
                end
            end
        end
        ready_q = ready;
    end

    task automatic start_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        write_index = wr;
        read_index  = !wr;
        addr        = a;
        write_data  = d;
        e.is_rd = !wr;
        e.cyc   = cyc + 1 + (wr ? LAT + 1 : LAT + 4);
        e.blk   = '0;
        if (wr) model_mem[a[11:2]] = d;
        else    e.blk = model_block(a);
        sb.push_back(e);
    endtask

    task automatic finish_req();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_val("ready_timeout", 128'd0, 128'd1);
        read_index  = 1'b0;
        write_index = 1'b0;
        @(negedge clk);
        #1;
        check_val("ready_after_drop", 128'(ready), 128'd0);
        check_val("busy_after_drop", 128'(busy), 128'd0);
    endtask

    task automatic apply_reset();
        read_index  = 1'b0;
        write_index = 1'b0;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    initial begin
        int rc0;
        addr       = '0;
        write_data = '0;
        apply_reset();
        repeat (3) @(negedge clk);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_ready", 128'(ready), 128'd0);
        check_val("rst_block", block_out, 128'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: plain read after reset
        start_req(1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check_val("busy_after_accept", 128'(busy), 128'd1);
        finish_req();

        // 2: write then read of the same block
        start_req(1'b1, 32'h44, 32'hDEADBEEF);
        finish_req();
        start_req(1'b0, 32'h48, 32'h0);
        finish_req();

        // 3: wrap-around and read/write collision
        start_req(1'b1, 32'h1000, 32'h12345678);
        finish_req();
        start_req(1'b1, 32'h8, 32'hA5A50001);
        read_index = 1'b1;
        finish_req();
        start_req(1'b0, 32'h0, 32'h0);
        check_val("model_collision", model_block(32'h0),
                  128'h00000000_A5A50001_00000000_12345678);
        finish_req();

        // 4: request dropped during WAIT, addr wiggled
        rc0 = ready_cnt;
        start_req(1'b0, 32'h44, 32'h0);
        repeat (2) @(negedge clk);
        read_index = 1'b0;
        addr       = 32'h100;
        finish_req();
        check_val("ready_pulse_len", 128'(ready_cnt - rc0), 128'd1);

        // 5a: reset during BURST
        start_req(1'b0, 32'h48, 32'h0);
        repeat (6) @(negedge clk);
        check_val("busy_in_burst", 128'(busy), 128'd1);
        apply_reset();
        #1;
        check_val("arst_busy", 128'(busy), 128'd0);
        check_val("arst_ready", 128'(ready), 128'd0);
        check_val("arst_block", block_out, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 5b: reset during WAIT of a write discards the store
        start_req(1'b1, 32'h80, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        apply_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_req(1'b0, 32'h80, 32'h0);
        finish_req();
        start_req(1'b0, 32'h44, 32'h0);
        finish_req();

        repeat (2) @(negedge clk);
        check_val("sb_drained", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Main-memory responder serving the miss/write-back traffic issued by cache_level_2. It is the far end of the mem_read_index / mem_write_index request interface.
- Reads: returns a full 4-word (128-bit) block for cache_level_2 refills.
- Writes: performs single-word stores.
- Models DRAM access latency with a programmable delay and signals completion with a four-phase ready handshake. It replaces the zero-latency datamemory behind the L2.

Parameters:
- DEPTH, 1024, number of 32-bit words in the storage array (power of two).
- LATENCY, 4, access delay cycles before data movement (>= 1).
- WORDS, 4, words per block; fixed, BLOCK_W = 32*WORDS = 128.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- read_index  in  1  block-read request, level, held by requester until ready.
- write_index  in  1  word-write request, level, held by requester until ready.
- addr  in  32  byte address; bits [1:0] ignored.
- write_data  in  32  store data.
- busy  out  1  transaction in progress (WAIT/BURST/WRITE/DONE).
- ready  out  1  transaction complete; high in DONE only.
- block_out  out  128  refill block; word k at bits [32k+31:32k].

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-low.
- Reset (rst=0, any state):
  - State goes to IDLE; busy=0, ready=0, block_out=0.
  - Latency counter and burst index go to 0; captured addr/data go to 0; the storage array is zeroed.
  - Reset mid-transaction aborts the transaction. No partial write is committed after reset release.
- Address mapping:
  - word index = addr[log2(DEPTH)+1:2]; upper bits ignored (wrap modulo DEPTH).
  - Block base for reads = word index with its low 2 bits cleared.
- FSM states: IDLE, WAIT, BURST, WRITE, DONE.
- IDLE:
  - If write_index=1: capture addr and write_data, set op=WR, counter=LATENCY-1, go to WAIT.
  - Else if read_index=1: capture addr, set op=RD, counter=LATENCY-1, go to WAIT.
  - Write has priority when both are asserted; the read remains pending and is accepted after DONE/IDLE.
- WAIT:
  - If counter==0: go to BURST (op=RD, burst index=0) or WRITE (op=WR).
  - Else: counter-1.
  - Inputs are ignored; captured values are used.
- BURST:
  - Each cycle, block_out[32k+31:32k] <= mem[base+k] for k = burst index; index+1.
  - After k=WORDS-1, go to DONE. Exactly WORDS cycles.
- WRITE: mem[word index] <= captured data (one cycle); go to DONE.
- DONE:
  - ready=1.
  - Stay while read_index|write_index; go to IDLE when both are 0.
  - block_out holds its value until the next read's BURST.
- Latency, counted from the accepting clk edge E0:
  - Read: ready rises at edge E0+LATENCY+WORDS.
  - Write: ready rises at edge E0+LATENCY+1.
- Requests dropped before ready: the transaction still completes. ready is high for exactly one cycle (DONE sees the request low).
- busy = (state != IDLE); registered-state decode, no combinational path from inputs.
- Back-to-back: the minimum gap between transactions is one IDLE cycle after DONE.
- Read of a word written earlier returns the new value (write is committed before DONE).

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, WAIT, BURST, WRITE, DONE};
  - WORDS=4, BLOCK_W=128, op encoding RD/WR.
- Sub-module mem_resp_array: DEPTH x 32 synchronous-write array with combinational read, clear-on-reset, one write port, one read port.
- FSM, counter and block assembly stay in the top module.

Test Plan (LATENCY=4, DEPTH=1024):
1. Reset then read: read_index=1, addr=0x40 after reset -> busy next cycle; ready at E0+8; block_out=0. Drop read -> ready low next cycle, busy=0.
2. Write then read:
   - Write addr=0x44, data=0xDEADBEEF -> ready at E0+5.
   - Then read addr=0x48 -> block_out=0x00000000_00000000_DEADBEEF_00000000.
3. Wrap-around and collision:
   - Write 0x12345678 to addr=0x1000 (= DEPTH*4) -> read addr=0x0 returns word0=0x12345678.
   - read_index=1 and write_index=1 together -> write performed first; then the read is accepted and its block reflects the write.
4. Request dropped early: assert read_index for 2 cycles, then deassert -> read still completes; ready high exactly one cycle at E0+8; addr changes during WAIT have no effect.
5. Reset mid-operation:
   - Pull rst low during BURST -> busy=0, ready=0, block_out=0 immediately (asynchronous).
   - Pull rst low during WAIT of a write -> subsequent read of that address returns 0.
